ppu_bg_fetch_sequencer: RTL and testbench
=========================================

// Module: ppu_bg_fetch_sequencer
// PURPOSE
//  Sequences PPU background fetches: dot/scanline timing, 8-dot NT/AT/PT-lo/PT-hi slots on VRAM bus.
//  Emits reload strobe for the tile shift registers and scroll (v) update strobes.
//  Sits between the PPU clock divider (dot_en) and the VRAM port/scroll logic.
// PARAMETERS
//  DOTS_PER_LINE  341  dots per scanline (0..340)
//  LINES          262  scanlines per frame (0..261)
//  PRE_LINE       261  pre-render scanline index
//  VBL_LINE       241  scanline on which vblank starts
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, synchronous, active-high
//  dot_en       in   1   one-cycle PPU dot tick; all state advances only when 1
//  render_en    in   1   PPUMASK bg|sprite enable
//  v_addr       in   15  loopy v: [14:12] fine_y, [11:10] NT, [9:5] coarse_y, [4:0] coarse_x
//  bg_pt_sel    in   1   PPUCTRL bg pattern table select
//  vram_addr    out  14  VRAM read address
//  vram_rd      out  1   read request, valid on address dot
//  vram_data    in   8   read data, sampled on the dot_en after vram_rd
//  nt_byte/pt_lo/pt_hi out 8  latched tile index / pattern bytes
//  at_bits      out  2   palette bits for current tile
//  tile_valid   out  1   pulse: reload shift registers
//  inc_hori_v, inc_vert_v, copy_hori_v, copy_vert_v  out 1  scroll strobes
//  dot, scanline  out 9  current position;  odd_frame out 1;  vblank_start out 1 pulse
// BEHAVIOUR
//  Reset: dot=0, scanline=PRE_LINE, odd_frame=0, FSM=F_IDLE, all data outputs and strobes 0.
//  Dot advance: dot wraps 340->0 with scanline+1; scanline 261->0 toggles odd_frame.
//  Odd skip: scanline=PRE_LINE, dot=339, odd_frame=1, render_en=1 -> next dot is (0,0).
//  Fetch window: scanline 0..239 or PRE_LINE, dots 1..256 and 321..336, render_en=1.
//  FSM F_IDLE,F_NT,F_AT,F_LO,F_HI; each state spans 2 dots (addr dot, data dot);
//   slot phase=dot[2:0]: 1 NT addr, 2 latch; 3 AT, 4 latch; 5 LO, 6 latch; 7 HI, 0 latch.
//   NT addr = 14'h2000|v[11:0]; AT addr = 14'h23C0|{v[11:10],4'b0,v[9:7],v[4:2]}.
//   at_bits = AT byte >> {v[6],v[1],1'b0} [1:0]; PT lo = {bg_pt_sel,nt_byte,1'b0,v[14:12]}; hi = lo|8.
//  Phase 0 (dot 8,16..256,328,336): tile_valid=1, inc_hori_v=1, same dot_en cycle.
//  Dot 256: inc_vert_v; dot 257: copy_hori_v; PRE_LINE dots 280..304: copy_vert_v.
//  Dots 337,339: dummy NT reads (vram_rd=1, no tile_valid).
//  vblank_start pulses at (VBL_LINE, 1) regardless of render_en.
//  Strobes and vram_rd are 1 only in the clk cycle where dot_en=1; 0 otherwise.
//  render_en=0: no vram_rd, no v strobes, no tile_valid; counters run; FSM->F_IDLE next dot.
//  render_en falls mid-slot: partial tile discarded, latches hold; re-enable resumes at next phase 1.
//  rst mid-fetch: all outputs at reset values next cycle; no pending read completes.
// STRUCTURE
//  ppu_pkg: fetch_state_t enum; NT_BASE, AT_BASE, window dot constants, PRE_LINE/VBL_LINE.
//  Sub-module ppu_dot_timer: dot/scanline/odd_frame counters + skip logic; FSM/addressing here.
// TESTING
//  Line 0, v=0, pt_sel=0, NT data 8'h24: dot1 addr 2000, dot3 23C0, dot5 0240, dot7 0248, dot8 tile_valid+inc_hori_v.
//  v=15'h0042, AT byte 8'b11100100: AT addr 23C0, at_bits=2'b11; v=0 gives 2'b00.
//  Line 10: inc_vert_v only at dot 256, copy_hori_v only 257; PRE_LINE copy_vert_v 25 dots 280..304.
//  render_en=1 odd frame: 89341 dot_en ticks per frame; render_en=0: 89342; vblank_start at (241,1).
//  render_en drops at phase 5 -> vram_rd 0 from next dot, no tile_valid at phase 0.
//  rst asserted at phase 6 -> vram_rd, strobes 0 next cycle; dot=0, scanline=261.

Source files
------------

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ppu_pkg
// Description : Shared types, frame/fetch timing constants and VRAM address
//               helpers for the PPU background fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    typedef enum logic [2:0] {
        F_IDLE = 3'd0,
        F_NT   = 3'd1,
        F_AT   = 3'd2,
        F_LO   = 3'd3,
        F_HI   = 3'd4
    } fetch_state_t;

    localparam logic [13:0] NT_BASE = 14'h2000;
    localparam logic [13:0] AT_BASE = 14'h23C0;

    localparam int DEF_DOTS_PER_LINE = 341;
    localparam int DEF_LINES         = 262;
    localparam int DEF_PRE_LINE      = 261;
    localparam int DEF_VBL_LINE      = 241;
    localparam int DEF_VIS_LINES     = 240;

    localparam logic [8:0] FETCH_FIRST     = 9'd1;
    localparam logic [8:0] FETCH_LAST      = 9'd256;
    localparam logic [8:0] PREFETCH_FIRST  = 9'd321;
    localparam logic [8:0] PREFETCH_LAST   = 9'd336;
    localparam logic [8:0] DUMMY_NT_DOT0   = 9'd337;
    localparam logic [8:0] DUMMY_NT_DOT1   = 9'd339;
    localparam logic [8:0] INC_VERT_DOT    = 9'd256;
    localparam logic [8:0] COPY_HORI_DOT   = 9'd257;
    localparam logic [8:0] COPY_VERT_FIRST = 9'd280;
    localparam logic [8:0] COPY_VERT_LAST  = 9'd304;
    localparam logic [8:0] ODD_SKIP_DOT    = 9'd339;
    localparam logic [8:0] VBL_DOT         = 9'd1;

    function automatic logic [13:0] nt_addr(input logic [11:0] v_low);
        return NT_BASE | {2'b00, v_low};
    endfunction

    function automatic logic [13:0] at_addr(input logic [1:0] nt_sel,
                                            input logic [2:0] cy_hi,
                                            input logic [2:0] cx_hi);
        return AT_BASE | {2'b00, nt_sel, 4'b0000, cy_hi, cx_hi};
    endfunction

    function automatic logic [13:0] pt_addr(input logic       sel,
                                            input logic [7:0] tile,
                                            input logic [2:0] fine_y);
        return {1'b0, sel, tile, 1'b0, fine_y};
    endfunction

    // Picks the 2-bit palette quadrant for the tile out of an attribute byte.
    function automatic logic [1:0] at_select(input logic [7:0] at_byte,
                                             input logic       y_half,
                                             input logic       x_half);
        logic [1:0] sel;
        case ({y_half, x_half})
            2'b00:   sel = at_byte[1:0];
            2'b01:   sel = at_byte[3:2];
            2'b10:   sel = at_byte[5:4];
            default: sel = at_byte[7:6];
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_dot_timer.sv
`default_nettype none
// ============================================================================
// Module      : ppu_dot_timer
// Description : Dot / scanline / odd-frame counters with the odd-frame skip.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_dot_timer
    import ppu_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int LINES         = DEF_LINES,
    parameter int PRE_LINE      = DEF_PRE_LINE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dot_en,
    input  logic       render_en,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic       odd_frame
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] LAST_LINE = 9'(LINES - 1);
    localparam logic [8:0] PRE_L     = 9'(PRE_LINE);

    logic [8:0] dot_q, dot_d;
    logic [8:0] line_q, line_d;
    logic       odd_q, odd_d;
    logic       w_skip;
    logic       w_wrap;

    // Odd rendered frames drop the last pre-render dot.
    assign w_skip = (line_q == PRE_L) && (dot_q == ODD_SKIP_DOT) && odd_q && render_en;
    assign w_wrap = w_skip || (dot_q == LAST_DOT);

    always_comb begin
        dot_d  = dot_q;
        line_d = line_q;
        odd_d  = odd_q;
        if (dot_en) begin
            if (w_wrap) begin
                dot_d = 9'd0;
                if (line_q == LAST_LINE) begin
                    line_d = 9'd0;
                    odd_d  = ~odd_q;
                end else begin
                    line_d = line_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dot_q  <= 9'd0;
            line_q <= PRE_L;
            odd_q  <= 1'b0;
        end else begin
            dot_q  <= dot_d;
            line_q <= line_d;
            odd_q  <= odd_d;
        end
    end

    assign dot       = dot_q;
    assign scanline  = line_q;
    assign odd_frame = odd_q;

endmodule
`default_nettype wire

// File: rtl/ppu_bg_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ppu_bg_fetch_sequencer
// Description : PPU background fetch sequencer: NT/AT/PT slot FSM, VRAM read
//               requests, tile latches and scroll update strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_bg_fetch_sequencer
    import ppu_pkg::*;
#(
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int LINES         = DEF_LINES,
    parameter int PRE_LINE      = DEF_PRE_LINE,
    parameter int VBL_LINE      = DEF_VBL_LINE,
    parameter int VIS_LINES     = DEF_VIS_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dot_en,
    input  logic        render_en,
    input  logic [14:0] v_addr,
    input  logic        bg_pt_sel,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    output logic [7:0]  nt_byte,
    output logic [7:0]  pt_lo,
    output logic [7:0]  pt_hi,
    output logic [1:0]  at_bits,
    output logic        tile_valid,
    output logic        inc_hori_v,
    output logic        inc_vert_v,
    output logic        copy_hori_v,
    output logic        copy_vert_v,
    output logic [8:0]  dot,
    output logic [8:0]  scanline,
    output logic        odd_frame,
    output logic        vblank_start
);

    localparam logic [8:0] PRE_L = 9'(PRE_LINE);
    localparam logic [8:0] VBL_L = 9'(VBL_LINE);
    localparam logic [8:0] VIS_L = 9'(VIS_LINES);

    fetch_state_t state_q, state_d;

    logic [7:0]  nt_q, lo_q, hi_q;
    logic [1:0]  at_q;
    logic [2:0]  w_phase;
    logic        w_render_line;
    logic        w_in_window;
    logic        w_active;
    logic        w_dummy;
    logic [13:0] w_nt_addr, w_at_addr, w_pt_addr;
    logic        w_rd;
    logic [13:0] w_addr;
    logic        w_tile;
    logic        w_lat_nt, w_lat_at, w_lat_lo, w_lat_hi;

    ppu_dot_timer #(
        .DOTS_PER_LINE (DOTS_PER_LINE),
        .LINES         (LINES),
        .PRE_LINE      (PRE_LINE)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .dot_en    (dot_en),
        .render_en (render_en),
        .dot       (dot),
        .scanline  (scanline),
        .odd_frame (odd_frame)
    );

    assign w_phase       = dot[2:0];
    assign w_render_line = (scanline < VIS_L) || (scanline == PRE_L);
    assign w_in_window   = w_render_line &&
                           (((dot >= FETCH_FIRST) && (dot <= FETCH_LAST)) ||
                            ((dot >= PREFETCH_FIRST) && (dot <= PREFETCH_LAST)));
    assign w_active      = dot_en && render_en;
    assign w_dummy       = w_render_line && ((dot == DUMMY_NT_DOT0) || (dot == DUMMY_NT_DOT1));

    assign w_nt_addr = nt_addr(v_addr[11:0]);
    assign w_at_addr = at_addr(v_addr[11:10], v_addr[9:7], v_addr[4:2]);
    assign w_pt_addr = pt_addr(bg_pt_sel, nt_q, v_addr[14:12]);

    // Each slot only continues if the previous half completed while rendering;
    // a broken chain drops to idle until the next tile boundary (phase 1).
    always_comb begin
        state_d  = state_q;
        w_rd     = 1'b0;
        w_addr   = 14'd0;
        w_tile   = 1'b0;
        w_lat_nt = 1'b0;
        w_lat_at = 1'b0;
        w_lat_lo = 1'b0;
        w_lat_hi = 1'b0;
        if (dot_en) begin
            state_d = F_IDLE;
            if (render_en && w_in_window) begin
                case (w_phase)
                    3'd1: begin
                        state_d = F_NT;
                        w_rd    = 1'b1;
                        w_addr  = w_nt_addr;
                    end
                    3'd2: if (state_q == F_NT) begin
                        state_d  = F_NT;
                        w_lat_nt = 1'b1;
                    end
                    3'd3: if (state_q == F_NT) begin
                        state_d = F_AT;
                        w_rd    = 1'b1;
                        w_addr  = w_at_addr;
                    end
                    3'd4: if (state_q == F_AT) begin
                        state_d  = F_AT;
                        w_lat_at = 1'b1;
                    end
                    3'd5: if (state_q == F_AT) begin
                        state_d = F_LO;
                        w_rd    = 1'b1;
                        w_addr  = w_pt_addr;
                    end
                    3'd6: if (state_q == F_LO) begin
                        state_d  = F_LO;
                        w_lat_lo = 1'b1;
                    end
                    3'd7: if (state_q == F_LO) begin
                        state_d = F_HI;
                        w_rd    = 1'b1;
                        w_addr  = w_pt_addr | 14'h0008;
                    end
                    default: if (state_q == F_HI) begin
                        state_d  = F_IDLE;
                        w_lat_hi = 1'b1;
                        w_tile   = 1'b1;
                    end
                endcase
            end else if (render_en && w_dummy) begin
                w_rd   = 1'b1;
                w_addr = w_nt_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nt_q <= 8'd0;
            at_q <= 2'd0;
            lo_q <= 8'd0;
            hi_q <= 8'd0;
        end else begin
            if (w_lat_nt) nt_q <= vram_data;
            if (w_lat_at) at_q <= at_select(vram_data, v_addr[6], v_addr[1]);
            if (w_lat_lo) lo_q <= vram_data;
            if (w_lat_hi) hi_q <= vram_data;
        end
    end

    assign vram_rd     = w_rd;
    assign vram_addr   = w_addr;
    assign tile_valid  = w_tile;
    assign nt_byte     = nt_q;
    assign at_bits     = at_q;
    assign pt_lo       = lo_q;
    assign pt_hi       = hi_q;

    // Coarse-X steps on every tile boundary of the window, even mid-tile re-enable.
    assign inc_hori_v  = w_active && w_in_window && (w_phase == 3'd0);
    assign inc_vert_v  = w_active && w_render_line && (dot == INC_VERT_DOT);
    assign copy_hori_v = w_active && w_render_line && (dot == COPY_HORI_DOT);
    assign copy_vert_v = w_active && (scanline == PRE_L) &&
                         (dot >= COPY_VERT_FIRST) && (dot <= COPY_VERT_LAST);
    assign vblank_start = dot_en && (scanline == VBL_L) && (dot == VBL_DOT);

endmodule
`default_nettype wire

// File: tb/tb_ppu_bg_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_bg_fetch_sequencer
// Description : Randomised bench with a position/slot reference model for the
//               PPU background fetch sequencer (short frame geometry).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_bg_fetch_sequencer;

    localparam int DL  = 341;
    localparam int LN  = 20;
    localparam int PRE = 19;
    localparam int VBL = 17;
    localparam int VIS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dot_en = 1'b0;
    logic        render_en = 1'b0;
    logic [14:0] v_addr = '0;
    logic        bg_pt_sel = 1'b0;
    logic [7:0]  vram_data = '0;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  nt_byte, pt_lo, pt_hi;
    logic [1:0]  at_bits;
    logic        tile_valid, inc_hori_v, inc_vert_v, copy_hori_v, copy_vert_v;
    logic [8:0]  dot, scanline;
    logic        odd_frame, vblank_start;

    always #5 clk = ~clk;

    ppu_bg_fetch_sequencer #(
        .DOTS_PER_LINE (DL),
        .LINES         (LN),
        .PRE_LINE      (PRE),
        .VBL_LINE      (VBL),
        .VIS_LINES     (VIS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dot_en       (dot_en),
        .render_en    (render_en),
        .v_addr       (v_addr),
        .bg_pt_sel    (bg_pt_sel),
        .vram_addr    (vram_addr),
        .vram_rd      (vram_rd),
        .vram_data    (vram_data),
        .nt_byte      (nt_byte),
        .pt_lo        (pt_lo),
        .pt_hi        (pt_hi),
        .at_bits      (at_bits),
        .tile_valid   (tile_valid),
        .inc_hori_v   (inc_hori_v),
        .inc_vert_v   (inc_vert_v),
        .copy_hori_v  (copy_hori_v),
        .copy_vert_v  (copy_vert_v),
        .dot          (dot),
        .scanline     (scanline),
        .odd_frame    (odd_frame),
        .vblank_start (vblank_start)
    );

    // Reference model: frame position, tile-in-progress flag, latched bytes.
    int       m_dot  = 0;
    int       m_line = PRE;
    bit       m_odd  = 0;
    bit       m_alive = 0;
    int       m_nt = 0, m_lo = 0, m_hi = 0, m_at = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Last sampled DUT outputs plus the model position they belong to.
    bit       s_rd, s_tv, s_ihv, s_ivv, s_chv, s_cvv, s_vbl;
    int       s_addr, s_mdot, s_mline;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model line %0d dot %0d) @%0t",
                     nm, act, exp, m_line, m_dot, $time);
        end
    endtask

    task automatic tick(input bit de, input bit re, input bit rs);
        int ph, lat, shamt;
        bit rl, win, act;
        bit e_rd, e_tv, e_ihv, e_ivv, e_chv, e_cvv, e_vbl;
        int e_addr, nta, ata, pta;
        dot_en    = de;
        render_en = re;
        rst       = rs;
        @(negedge clk);
        ph  = m_dot % 8;
        rl  = (m_line < VIS) || (m_line == PRE);
        win = rl && (((m_dot >= 1) && (m_dot <= 256)) || ((m_dot >= 321) && (m_dot <= 336)));
        act = de && re;
        nta = 'h2000 + (v_addr % 4096);
        ata = 'h23C0 + ((v_addr >> 10) % 4) * 1024 + ((v_addr >> 7) % 8) * 8 + (v_addr >> 2) % 8;
        pta = bg_pt_sel * 4096 + m_nt * 16 + (v_addr >> 12);
        e_rd = 0; e_addr = 0; e_tv = 0; lat = -1;
        if (act && win) begin
            if (ph == 1) begin
                e_rd = 1; e_addr = nta;
            end else if (m_alive) begin
                case (ph)
                    3: begin e_rd = 1; e_addr = ata; end
                    5: begin e_rd = 1; e_addr = pta; end
                    7: begin e_rd = 1; e_addr = pta + 8; end
                    0: begin lat = 0; e_tv = 1; end
                    default: lat = ph;
                endcase
            end
        end else if (act && rl && ((m_dot == 337) || (m_dot == 339))) begin
            e_rd = 1; e_addr = nta;
        end
        e_ihv = act && win && (ph == 0);
        e_ivv = act && rl && (m_dot == 256);
        e_chv = act && rl && (m_dot == 257);
        e_cvv = act && (m_line == PRE) && (m_dot >= 280) && (m_dot <= 304);
        e_vbl = de && (m_line == VBL) && (m_dot == 1);

        chk("vram_rd", 32'(vram_rd), 32'(e_rd));
        chk("vram_addr", 32'(vram_addr), 32'(e_addr));
        chk("tile_valid", 32'(tile_valid), 32'(e_tv));
        chk("v_strobes", {28'd0, inc_hori_v, inc_vert_v, copy_hori_v, copy_vert_v},
            {28'd0, e_ihv, e_ivv, e_chv, e_cvv});
        chk("vblank_start", 32'(vblank_start), 32'(e_vbl));
        chk("position", {14'd0, odd_frame, scanline, dot}, 32'(m_odd * 262144 + m_line * 512 + m_dot));
        chk("latches", {6'd0, at_bits, pt_hi, pt_lo, nt_byte},
            32'(m_at * 16777216 + m_hi * 65536 + m_lo * 256 + m_nt));

        s_rd = vram_rd; s_addr = 32'(vram_addr); s_tv = tile_valid; s_ihv = inc_hori_v;
        s_ivv = inc_vert_v; s_chv = copy_hori_v; s_cvv = copy_vert_v; s_vbl = vblank_start;
        s_mdot = m_dot; s_mline = m_line;

        @(posedge clk);
        if (rs) begin
            m_dot = 0; m_line = PRE; m_odd = 0; m_alive = 0;
            m_nt = 0; m_lo = 0; m_hi = 0; m_at = 0;
        end else if (de) begin
            shamt = ((v_addr >> 6) % 2) * 4 + ((v_addr >> 1) % 2) * 2;
            case (lat)
                2: m_nt = vram_data;
                4: m_at = (vram_data >> shamt) % 4;
                6: m_lo = vram_data;
                0: m_hi = vram_data;
                default: ;
            endcase
            if (!re) m_alive = 0;
            else if (ph == 1) m_alive = win;
            if ((m_line == PRE) && (m_dot == 339) && m_odd && re) begin
                m_dot = 0; m_line = 0; m_odd = !m_odd;
            end else if (m_dot == DL - 1) begin
                m_dot = 0;
                if (m_line == LN - 1) begin m_line = 0; m_odd = !m_odd; end
                else m_line++;
            end else begin
                m_dot++;
            end
        end
        #1;
    endtask

    task automatic rnd_inputs();
        v_addr    = 15'($urandom);
        vram_data = 8'($urandom);
        bg_pt_sel = 1'($urandom);
    endtask

    task automatic run_to(input int ln, input int dt, input bit re, input bit rnd);
        int n = 0;
        while (!((m_line == ln) && (m_dot == dt)) && (n < 30000)) begin
            if (rnd) rnd_inputs();
            tick(1, re, 0);
            n++;
        end
        chk("run_to_in_budget", 32'(n < 30000), 32'd1);
    endtask

    initial begin
        logic [13:0] tile0_addr [0:8];
        int n_ivv, d_ivv, n_chv, d_chv, n_ihv, n_dummy, n_bad;
        int n_tick, n_cvv, n_vbl, vbl_l, vbl_d, exp_ticks;
        bit re_r;

        tile0_addr = '{14'h0, 14'h2000, 14'h0, 14'h23C0, 14'h0, 14'h0240, 14'h0, 14'h0248, 14'h0};

        repeat (3) tick(0, 0, 1);
        chk("reset_dot", 32'(dot), 32'd0);
        chk("reset_scanline", 32'(scanline), 32'(PRE));
        chk("reset_odd_frame", 32'(odd_frame), 32'd0);
        chk("reset_latches", {6'd0, at_bits, pt_hi, pt_lo, nt_byte}, 32'd0);

        // Line 0, v=0, NT byte 0x24: first tile address sequence.
        v_addr = '0; bg_pt_sel = 0; vram_data = 8'h24;
        run_to(0, 0, 1, 0);
        for (int d = 0; d <= 8; d++) begin
            tick(1, 1, 0);
            chk("tile0_rd", 32'(s_rd), 32'(tile0_addr[d] != 14'h0));
            chk("tile0_addr", 32'(s_addr), 32'(tile0_addr[d]));
        end
        chk("tile0_valid_inc_hori", {30'd0, s_tv, s_ihv}, 32'd3);
        chk("tile0_nt_byte", 32'(nt_byte), 32'h24);

        // Attribute quadrant selection.
        v_addr = 15'h0042; vram_data = 8'b1110_0100;
        for (int d = 9; d <= 16; d++) begin
            tick(1, 1, 0);
            if (d == 11) chk("at_addr_v42", 32'(s_addr), 32'h23C0);
        end
        chk("at_bits_v42", 32'(at_bits), 32'd3);
        v_addr = 15'h0000;
        repeat (8) tick(1, 1, 0);
        chk("at_bits_v0", 32'(at_bits), 32'd0);

        // Line 10: one vertical increment at 256, one horizontal copy at 257.
        run_to(10, 0, 1, 1);
        n_ivv = 0; d_ivv = -1; n_chv = 0; d_chv = -1; n_ihv = 0; n_dummy = 0;
        for (int i = 0; i < DL; i++) begin
            rnd_inputs();
            tick(1, 1, 0);
            if (s_ivv) begin n_ivv++; d_ivv = s_mdot; end
            if (s_chv) begin n_chv++; d_chv = s_mdot; end
            if (s_ihv) n_ihv++;
            if (s_rd && (s_mdot >= 337)) n_dummy++;
        end
        chk("line10_inc_vert_count", 32'(n_ivv), 32'd1);
        chk("line10_inc_vert_dot", 32'(d_ivv), 32'd256);
        chk("line10_copy_hori_count", 32'(n_chv), 32'd1);
        chk("line10_copy_hori_dot", 32'(d_chv), 32'd257);
        chk("line10_inc_hori_count", 32'(n_ihv), 32'd34);
        chk("line10_dummy_reads", 32'(n_dummy), 32'd2);

        // Line 11: render drops after the phase-5 read, resumes on phase 1.
        for (int d = 0; d <= 5; d++) begin rnd_inputs(); tick(1, 1, 0); end
        chk("drop_phase5_rd", 32'(s_rd), 32'd1);
        n_bad = 0;
        for (int d = 6; d <= 8; d++) begin
            rnd_inputs(); tick(1, 0, 0);
            n_bad += s_rd + s_tv + s_ihv;
        end
        chk("drop_no_activity", 32'(n_bad), 32'd0);
        rnd_inputs(); tick(1, 1, 0);
        chk("resume_phase1_rd", 32'(s_rd), 32'd1);
        chk("resume_phase1_addr", 32'(s_addr), 32'h2000 + 32'(v_addr % 4096));

        // Reset landing on a phase-6 data dot.
        for (int d = 10; d <= 13; d++) begin rnd_inputs(); tick(1, 1, 0); end
        rnd_inputs(); tick(1, 1, 1);
        chk("rst_mid_rd", 32'(vram_rd), 32'd0);
        chk("rst_mid_pos", {23'd0, scanline}, 32'(PRE));
        chk("rst_mid_dot", 32'(dot), 32'd0);
        chk("rst_mid_latches", {6'd0, at_bits, pt_hi, pt_lo, nt_byte}, 32'd0);
        chk("rst_mid_strobes", {27'd0, tile_valid, inc_hori_v, inc_vert_v, copy_hori_v, copy_vert_v}, 32'd0);

        // Randomised traffic with gapped dot_en and sporadic render/reset changes.
        re_r = 1;
        for (int i = 0; i < 8000; i++) begin
            rnd_inputs();
            if ($urandom_range(0, 299) == 0) re_r = !re_r;
            tick($urandom_range(0, 3) != 0, re_r, $urandom_range(0, 2999) == 0);
        end

        // Whole-frame lengths: two rendered frames (odd and even), one blank.
        run_to(0, 0, 1, 1);
        for (int f = 0; f < 3; f++) begin
            re_r = (f < 2);
            exp_ticks = (re_r && m_odd) ? DL * LN - 1 : DL * LN;
            n_tick = 0; n_cvv = 0; n_vbl = 0; vbl_l = -1; vbl_d = -1;
            do begin
                rnd_inputs();
                tick(1, re_r, 0);
                n_tick++;
                if (s_cvv) n_cvv++;
                if (s_vbl) begin n_vbl++; vbl_l = s_mline; vbl_d = s_mdot; end
            end while (!((dot == 9'd0) && (scanline == 9'd0)) && (n_tick < 20000));
            chk("frame_ticks", 32'(n_tick), 32'(exp_ticks));
            chk("frame_copy_vert", 32'(n_cvv), re_r ? 32'd25 : 32'd0);
            chk("frame_vblank_count", 32'(n_vbl), 32'd1);
            chk("frame_vblank_pos", 32'(vbl_l * 1000 + vbl_d), 32'(VBL * 1000 + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
